// File: rtl/tx_doorbell_arbiter_if.sv
// rtl/tx_doorbell_arbiter_if.sv - doorbell source, output and status bundle for tx_doorbell_arbiter
interface tx_doorbell_arbiter_if #(
   parameter int IN_COUNT          = 4,
   parameter int QUEUE_INDEX_WIDTH = 13,
   parameter int FUNCTION_ID_WIDTH = 8,
   parameter int FIFO_DEPTH        = 16
);
   logic [IN_COUNT*QUEUE_INDEX_WIDTH-1:0] s_doorbell_queue;
   logic [IN_COUNT*FUNCTION_ID_WIDTH-1:0] s_doorbell_func;
   logic [IN_COUNT-1:0]                   s_doorbell_valid;
   logic [IN_COUNT-1:0]                   s_doorbell_ready;
   logic [QUEUE_INDEX_WIDTH-1:0]          m_axis_doorbell_queue;
   logic [FUNCTION_ID_WIDTH-1:0]          m_axis_doorbell_func;
   logic                                  m_axis_doorbell_valid;
   logic [$clog2(FIFO_DEPTH):0]           fifo_count;
   logic [31:0]                           coalesce_count;

   modport master (
      output s_doorbell_queue, s_doorbell_func, s_doorbell_valid,
      input  s_doorbell_ready,
      input  m_axis_doorbell_queue, m_axis_doorbell_func, m_axis_doorbell_valid,
      input  fifo_count, coalesce_count
   );

   modport slave (
      input  s_doorbell_queue, s_doorbell_func, s_doorbell_valid,
      output s_doorbell_ready,
      output m_axis_doorbell_queue, m_axis_doorbell_func, m_axis_doorbell_valid,
      output fifo_count, coalesce_count
   );
endinterface

// File: rtl/tx_doorbell_arbiter.sv
// rtl/tx_doorbell_arbiter.sv - round-robin merge of TX doorbell sources into one valid-only stream
// Grants go into a FIFO; a repeat of the last written {queue,func} is absorbed instead of stored.
module tx_doorbell_arbiter #(
   parameter int IN_COUNT          = 4,
   parameter int QUEUE_INDEX_WIDTH = 13,
   parameter int FUNCTION_ID_WIDTH = 8,
   parameter int FIFO_DEPTH        = 16,
   parameter int MIN_GAP           = 0
) (
   input logic clk,
   input logic rst,
   tx_doorbell_arbiter_if.slave db_if
);
   localparam int PTR_W   = $clog2(FIFO_DEPTH);
   localparam int CNT_W   = PTR_W + 1;
   localparam int QW      = QUEUE_INDEX_WIDTH;
   localparam int FW      = FUNCTION_ID_WIDTH;
   localparam int ENTRY_W = QW + FW;
   localparam int RR_W    = (IN_COUNT > 1) ? $clog2(IN_COUNT) : 1;
   localparam int GAP_W   = (MIN_GAP > 0) ? $clog2(MIN_GAP + 1) : 1;

   logic [RR_W-1:0]    rr_q, rr_d;
   logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [GAP_W-1:0]   gap_q, gap_d;
   logic [QW-1:0]      last_queue_q;
   logic [FW-1:0]      last_func_q;
   logic               last_valid_q, last_valid_d;
   logic [31:0]        coalesce_q;
   logic               m_valid_q;
   logic [QW-1:0]      m_queue_q;
   logic [FW-1:0]      m_func_q;
   logic [ENTRY_W-1:0] mem_q [FIFO_DEPTH];

   logic               grant_en;
   logic               grant_vld;
   logic [RR_W-1:0]    grant_idx;
   logic [IN_COUNT-1:0] ready;
   int                 cand;
   logic [QW-1:0]      sel_queue;
   logic [FW-1:0]      sel_func;
   logic               hit;
   logic               wr;
   logic               pop;

   // Registered occupancy only: a pop this cycle does not open a slot for a grant this cycle.
   assign grant_en = !rst && (count_q != CNT_W'(FIFO_DEPTH));

   always_comb begin
      grant_vld = 1'b0;
      grant_idx = '0;
      cand      = 0;
      for (int k = 0; k < IN_COUNT; k++) begin
         cand = int'(rr_q) + k;
         if (cand >= IN_COUNT) cand = cand - IN_COUNT;
         if (grant_en && !grant_vld && db_if.s_doorbell_valid[cand]) begin
            grant_vld = 1'b1;
            grant_idx = RR_W'(cand);
         end
      end
   end

   always_comb begin
      ready = '0;
      if (grant_vld) ready[grant_idx] = 1'b1;
   end

   assign sel_queue = db_if.s_doorbell_queue[int'(grant_idx)*QW +: QW];
   assign sel_func  = db_if.s_doorbell_func[int'(grant_idx)*FW +: FW];

   assign hit = grant_vld && last_valid_q && (sel_queue == last_queue_q) && (sel_func == last_func_q);
   assign wr  = grant_vld && !hit;
   assign pop = (count_q != '0) && (gap_q == '0);

   always_comb begin
      rr_d = rr_q;
      if (grant_vld) rr_d = (int'(grant_idx) == IN_COUNT - 1) ? '0 : grant_idx + RR_W'(1);

      count_d = count_q;
      if (wr && !pop)      count_d = count_q + CNT_W'(1);
      else if (!wr && pop) count_d = count_q - CNT_W'(1);

      gap_d = gap_q;
      if (pop)                gap_d = GAP_W'(MIN_GAP);
      else if (gap_q != '0)   gap_d = gap_q - GAP_W'(1);

      // Draining the last entry forgets it, so a later repeat is a fresh doorbell.
      last_valid_d = last_valid_q;
      if (wr)                                last_valid_d = 1'b1;
      else if (pop && count_q == CNT_W'(1))  last_valid_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (wr) mem_q[wr_ptr_q] <= {sel_queue, sel_func};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_q         <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         gap_q        <= '0;
         last_queue_q <= '0;
         last_func_q  <= '0;
         last_valid_q <= 1'b0;
         coalesce_q   <= '0;
         m_valid_q    <= 1'b0;
         m_queue_q    <= '0;
         m_func_q     <= '0;
      end else begin
         rr_q         <= rr_d;
         count_q      <= count_d;
         gap_q        <= gap_d;
         last_valid_q <= last_valid_d;
         m_valid_q    <= pop;
         if (wr) begin
            wr_ptr_q     <= wr_ptr_q + PTR_W'(1);
            last_queue_q <= sel_queue;
            last_func_q  <= sel_func;
         end
         if (hit) coalesce_q <= coalesce_q + 32'd1;
         if (pop) begin
            rd_ptr_q              <= rd_ptr_q + PTR_W'(1);
            {m_queue_q, m_func_q} <= mem_q[rd_ptr_q];
         end
      end
   end

   assign db_if.s_doorbell_ready      = ready;
   assign db_if.m_axis_doorbell_queue = m_queue_q;
   assign db_if.m_axis_doorbell_func  = m_func_q;
   assign db_if.m_axis_doorbell_valid = m_valid_q;
   assign db_if.fifo_count            = count_q;
   assign db_if.coalesce_count        = coalesce_q;
endmodule

// File: tb/tb_tx_doorbell_arbiter.sv
// tb/tb_tx_doorbell_arbiter.sv - directed table and sequence checks for tx_doorbell_arbiter
module tb_tx_doorbell_arbiter;
   localparam int N     = 4;
   localparam int QW    = 13;
   localparam int FW    = 8;
   localparam int DEPTH = 16;
   localparam int GAP   = 15;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   tx_doorbell_arbiter_if #(.IN_COUNT(N), .QUEUE_INDEX_WIDTH(QW), .FUNCTION_ID_WIDTH(FW),
                            .FIFO_DEPTH(DEPTH)) db_if ();

   tx_doorbell_arbiter #(.IN_COUNT(N), .QUEUE_INDEX_WIDTH(QW), .FUNCTION_ID_WIDTH(FW),
                         .FIFO_DEPTH(DEPTH), .MIN_GAP(GAP)) dut (
      .clk   (clk),
      .rst   (rst),
      .db_if (db_if)
   );

   typedef struct {
      logic [QW-1:0] q;
      logic [FW-1:0] f;
      int            c;
   } ev_t;

   typedef struct {
      logic [N-1:0] valid;
      logic [N-1:0] ready;
      int           fcnt;
   } vec_t;

   int  tests = 0;
   int  fails = 0;
   int  cyc   = 0;
   ev_t got[$];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (db_if.m_axis_doorbell_valid)
         got.push_back('{db_if.m_axis_doorbell_queue, db_if.m_axis_doorbell_func, cyc});
   end

   task automatic check(string name, int act, int exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(int s, logic v, int q, int f);
      db_if.s_doorbell_valid[s]           = v;
      db_if.s_doorbell_queue[s*QW +: QW]  = QW'(q);
      db_if.s_doorbell_func[s*FW +: FW]   = FW'(f);
   endtask

   task automatic idle_all();
      db_if.s_doorbell_valid = '0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle_all();
      step();
      step();
      rst = 1'b0;
      got.delete();
   endtask

   task automatic wait_emits(int n, int bound, string name);
      int k = 0;
      while (got.size() < n && k < bound) begin
         step();
         k++;
      end
      check(name, got.size(), n);
   endtask

   vec_t vt[12];
   ev_t  exp_q[$];
   int   grants[$];

   initial begin
      int idx;
      int exp_src;
      int saw_full;
      int bad;
      int n9;

      db_if.s_doorbell_valid = '0;
      db_if.s_doorbell_queue = '0;
      db_if.s_doorbell_func  = '0;

      vt[0]  = '{4'b0000, 4'b0000, 0};
      vt[1]  = '{4'b0001, 4'b0001, 0};
      vt[2]  = '{4'b0001, 4'b0001, 1};
      vt[3]  = '{4'b1111, 4'b0010, 1};
      vt[4]  = '{4'b1111, 4'b0100, 2};
      vt[5]  = '{4'b1111, 4'b1000, 3};
      vt[6]  = '{4'b1010, 4'b0010, 4};
      vt[7]  = '{4'b1010, 4'b1000, 5};
      vt[8]  = '{4'b0110, 4'b0010, 6};
      vt[9]  = '{4'b0100, 4'b0100, 7};
      vt[10] = '{4'b0000, 4'b0000, 8};
      vt[11] = '{4'b0101, 4'b0001, 8};

      // Reset state, with every source requesting
      for (int s = 0; s < N; s++) drive(s, 1'b1, 40 + s, s);
      step();
      step();
      check("rst_ready", int'(db_if.s_doorbell_ready), 0);
      check("rst_valid", int'(db_if.m_axis_doorbell_valid), 0);
      check("rst_queue", int'(db_if.m_axis_doorbell_queue), 0);
      check("rst_func", int'(db_if.m_axis_doorbell_func), 0);
      check("rst_fifo_count", int'(db_if.fifo_count), 0);
      check("rst_coalesce", int'(db_if.coalesce_count), 0);
      do_reset();

      // Table: arbitration order and occupancy per cycle
      for (int i = 0; i < 12; i++) begin
         for (int s = 0; s < N; s++) drive(s, vt[i].valid[s], i*4 + s + 16, s);
         #1;
         check($sformatf("tbl_ready[%0d]", i), int'(db_if.s_doorbell_ready), int'(vt[i].ready));
         check($sformatf("tbl_fcnt[%0d]", i), int'(db_if.fifo_count), vt[i].fcnt);
         for (int s = 0; s < N; s++)
            if (vt[i].ready[s]) exp_q.push_back('{QW'(i*4 + s + 16), FW'(s), 0});
         step();
      end
      idle_all();
      wait_emits(exp_q.size(), 400, "tbl_emit_count");
      for (int k = 0; k < exp_q.size() && k < got.size(); k++) begin
         check($sformatf("tbl_emit_q[%0d]", k), int'(got[k].q), int'(exp_q[k].q));
         check($sformatf("tbl_emit_f[%0d]", k), int'(got[k].f), int'(exp_q[k].f));
      end
      check("tbl_coalesce", int'(db_if.coalesce_count), 0);

      // Single doorbell: accept, pop, pulse two cycles later
      do_reset();
      drive(0, 1'b1, 5, 2);
      #1;
      check("single_ready", int'(db_if.s_doorbell_ready), 1);
      step();
      idle_all();
      check("single_valid_n1", int'(db_if.m_axis_doorbell_valid), 0);
      step();
      check("single_valid_n2", int'(db_if.m_axis_doorbell_valid), 1);
      check("single_queue", int'(db_if.m_axis_doorbell_queue), 5);
      check("single_func", int'(db_if.m_axis_doorbell_func), 2);
      step();
      check("single_valid_n3", int'(db_if.m_axis_doorbell_valid), 0);
      check("single_coalesce", int'(db_if.coalesce_count), 0);

      // Same queue, different function: both stored, both emitted
      got.delete();
      drive(0, 1'b1, 3, 1);
      #1;
      check("qf_ready0", int'(db_if.s_doorbell_ready), 1);
      step();
      drive(0, 1'b1, 3, 2);
      #1;
      check("qf_ready1", int'(db_if.s_doorbell_ready), 1);
      step();
      idle_all();
      wait_emits(2, 100, "qf_emit_count");
      if (got.size() >= 2) begin
         check("qf_q0", int'(got[0].q), 3);
         check("qf_f0", int'(got[0].f), 1);
         check("qf_q1", int'(got[1].q), 3);
         check("qf_f1", int'(got[1].f), 2);
      end
      check("qf_coalesce", int'(db_if.coalesce_count), 0);

      // Triple duplicate while the output gap is running
      do_reset();
      drive(0, 1'b1, 100, 0);
      step();
      idle_all();
      step();
      for (int k = 0; k < 3; k++) begin
         drive(1, 1'b1, 7, 0);
         #1;
         check($sformatf("dup_ready[%0d]", k), int'(db_if.s_doorbell_ready), 2);
         step();
      end
      idle_all();
      check("dup_fifo_count", int'(db_if.fifo_count), 1);
      check("dup_coalesce", int'(db_if.coalesce_count), 2);
      wait_emits(2, 100, "dup_emit_count");
      repeat (40) step();
      check("dup_emit_total", got.size(), 2);
      if (got.size() >= 2) begin
         check("dup_q0", int'(got[0].q), 100);
         check("dup_q1", int'(got[1].q), 7);
      end

      // Duplicate arriving as its match is popped is still absorbed; after drain it is fresh
      got.delete();
      drive(2, 1'b1, 9, 4);
      #1;
      check("popdup_ready0", int'(db_if.s_doorbell_ready), 4);
      step();
      #1;
      check("popdup_ready1", int'(db_if.s_doorbell_ready), 4);
      step();
      idle_all();
      check("popdup_coalesce", int'(db_if.coalesce_count), 3);
      repeat (30) step();
      check("popdup_emit_count", got.size(), 1);
      drive(2, 1'b1, 9, 4);
      step();
      idle_all();
      repeat (30) step();
      check("popdup_fresh_coalesce", int'(db_if.coalesce_count), 3);
      check("popdup_fresh_emit", got.size(), 2);

      // Fill to full, back-pressure, in-order drain at MIN_GAP+1 spacing
      do_reset();
      idx = 0;
      saw_full = 0;
      bad = 0;
      for (int k = 0; k < 600 && idx < 20; k++) begin
         drive(2, 1'b1, 300 + idx, 7);
         #1;
         if (int'(db_if.fifo_count) == DEPTH) begin
            saw_full = 1;
            if (db_if.s_doorbell_ready != '0) bad++;
         end else if (db_if.s_doorbell_ready != 4'b0100) begin
            bad++;
         end
         if (db_if.s_doorbell_ready == 4'b0100) idx++;
         step();
      end
      idle_all();
      check("full_reached", saw_full, 1);
      check("full_ready_errors", bad, 0);
      check("full_accepted", idx, 20);
      wait_emits(20, 400, "full_emit_count");
      for (int k = 0; k < got.size() && k < 20; k++) begin
         check($sformatf("full_q[%0d]", k), int'(got[k].q), 300 + k);
         if (k > 0) check($sformatf("full_gap[%0d]", k), got[k].c - got[k-1].c, GAP + 1);
      end

      // Reset drops buffered doorbells and counters
      do_reset();
      begin
         int seq[9] = '{200, 201, 201, 202, 202, 203, 203, 204, 205};
         for (int k = 0; k < 9; k++) begin
            drive(0, 1'b1, seq[k], 0);
            step();
         end
      end
      idle_all();
      check("mid_fifo_count", int'(db_if.fifo_count), 5);
      check("mid_coalesce", int'(db_if.coalesce_count), 3);
      check("mid_emit_before", got.size(), 1);
      rst = 1'b1;
      step();
      check("mid_rst_fifo_count", int'(db_if.fifo_count), 0);
      check("mid_rst_coalesce", int'(db_if.coalesce_count), 0);
      check("mid_rst_valid", int'(db_if.m_axis_doorbell_valid), 0);
      rst = 1'b0;
      got.delete();
      repeat (60) step();
      check("mid_no_emit", got.size(), 0);

      // All sources requesting: round-robin order survives back-pressure
      do_reset();
      for (int s = 0; s < N; s++) drive(s, 1'b1, 10 + s, s);
      exp_src = 0;
      bad = 0;
      for (int k = 0; k < 64; k++) begin
         #1;
         if (db_if.s_doorbell_ready != '0) begin
            check($sformatf("rr_grant[%0d]", grants.size()), int'(db_if.s_doorbell_ready), 1 << exp_src);
            grants.push_back(exp_src);
            exp_src = (exp_src + 1) % N;
         end else if (int'(db_if.fifo_count) != DEPTH) begin
            bad++;
         end
         step();
      end
      idle_all();
      check("rr_idle_errors", bad, 0);
      wait_emits(grants.size(), 1200, "rr_emit_count");
      for (int k = 0; k < grants.size() && k < got.size(); k++)
         check($sformatf("rr_emit_q[%0d]", k), int'(got[k].q), 10 + grants[k]);
      check("rr_coalesce", int'(db_if.coalesce_count), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/tx_doorbell_arbiter.md
# tx_doorbell_arbiter

Merges TX doorbell events from several sources into the single valid-only doorbell stream of the TX scheduler block. Sources include the PF queue manager, VF queue managers, and the host doorbell decoder. Each source has a valid/ready handshake. The block arbitrates round-robin, buffers events in a FIFO, and drops back-to-back duplicates for the same queue and function. Its output feeds the scheduler's `s_axis_doorbell_queue`/`_func`/`_valid` inputs, which have no backpressure.

## Interface
Parameters:
- `IN_COUNT`, 4 — number of doorbell sources; ≥1.
- `QUEUE_INDEX_WIDTH`, 13 — queue index width.
- `FUNCTION_ID_WIDTH`, 8 — PCIe function ID width (0 = PF, 1..n = VF).
- `FIFO_DEPTH`, 16 — entries; power of two, ≥2.
- `MIN_GAP`, 0 — idle cycles forced between consecutive output doorbells.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset; synchronous, active-high.
- `s_doorbell_queue`  in  IN_COUNT*QUEUE_INDEX_WIDTH  per-source queue index; source i occupies slice i.
- `s_doorbell_func`  in  IN_COUNT*FUNCTION_ID_WIDTH  per-source function ID.
- `s_doorbell_valid`  in  IN_COUNT  per-source valid.
- `s_doorbell_ready`  out  IN_COUNT  per-source ready; combinational, one-hot or zero.
- `m_axis_doorbell_queue`  out  QUEUE_INDEX_WIDTH  output queue index; registered.
- `m_axis_doorbell_func`  out  FUNCTION_ID_WIDTH  output function ID; registered.
- `m_axis_doorbell_valid`  out  1  single-cycle pulse; there is no ready.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  current occupancy; registered.
- `coalesce_count`  out  32  number of duplicate doorbells absorbed; wraps at 2^32.

## Operation
- Arbiter:
  - `grant_en` = `fifo_count != FIFO_DEPTH`. `fifo_count` is the registered value; a pop in the same cycle does not free space (no pop-through).
  - When `grant_en`, grant the first valid source at or after `rr_ptr`, searching upward with wrap.
  - `s_doorbell_ready[g]` = 1 only for the granted source g. The transfer completes that cycle.
  - On a transfer, `rr_ptr` becomes g+1 mod IN_COUNT. `rr_ptr` is otherwise unchanged.
- Coalescing:
  - Registers `last_queue`, `last_func`, `last_valid` track the most recently written FIFO entry.
  - A transfer whose {queue,func} equals {`last_queue`,`last_func`} while `last_valid`=1 is accepted but not written. `coalesce_count` increments by 1.
  - Otherwise the entry is written to the FIFO, the `last_*` registers are loaded, and `last_valid` is set to 1.
  - `last_valid` clears when a pop takes `fifo_count` from 1 to 0 with no write in the same cycle.
  - A coalesce hit in the same cycle as the pop of the matching entry is still absorbed. This is legal because that entry is emitted after the duplicate arrived.
- Pop/emit:
  - Pop when the FIFO is non-empty and `gap_cnt`==0.
  - A popped entry drives `m_axis_doorbell_*` with valid=1 on the next cycle. Valid returns to 0 the cycle after, unless another pop occurred.
  - On pop, `gap_cnt` loads MIN_GAP. While non-zero it decrements by 1 per cycle.
- `fifo_count` per cycle: +1 on write only, −1 on pop only, unchanged if both or neither.
- Width rules:
  - FIFO pointers are $clog2(FIFO_DEPTH) bits and wrap naturally.
  - Entry width = QUEUE_INDEX_WIDTH + FUNCTION_ID_WIDTH.

## Timing
- Reset values:
  - `s_doorbell_ready`=0 while `rst`=1.
  - `m_axis_doorbell_valid`=0, queue=0, func=0.
  - `fifo_count`=0, `coalesce_count`=0, `rr_ptr`=0, `gap_cnt`=0, `last_valid`=0.
  - FIFO contents are discarded.
- Assertion of `rst` mid-operation drops all buffered doorbells. The first accept is possible in the first cycle after `rst` deasserts.
- Latency:
  - Accept in cycle N writes the FIFO at the end of N.
  - Pop in cycle N+1.
  - `m_axis_doorbell_valid`=1 in cycle N+2.
- Throughput:
  - One accept per cycle.
  - One emit per MIN_GAP+1 cycles.
- Full: all readies are 0 while `fifo_count`==FIFO_DEPTH. Duplicates are also blocked in this state; no coalesce while full.
- IN_COUNT=1: arbitration is degenerate; `rr_ptr` stays 0.

## Test plan
- Single doorbell on source 0, then idle:
  - Stimulus: queue=5, func=2, valid for 1 cycle, FIFO empty.
  - Required: ready=1 that cycle; output valid pulse 2 cycles later with queue=5, func=2; `coalesce_count`=0.
- All 4 sources valid continuously with distinct queues 10..13, MIN_GAP=0:
  - Required: grants in order 0,1,2,3,0…; output order matches; no doorbell lost over 64 cycles.
- Source 1 presents queue=7, func=0 on 3 consecutive cycles; output path stalled by MIN_GAP=8:
  - Required: one FIFO write, `coalesce_count`=2, exactly one output with queue=7.
- FIFO_DEPTH=16, MIN_GAP=15, 20 distinct doorbells offered:
  - Required: `fifo_count` reaches 16 and all readies drop to 0.
  - Pending inputs are accepted as pops free space; all 20 are emitted in order, 16 cycles apart.
- Assert `rst` with 5 entries buffered and `coalesce_count`=3:
  - Required: the next cycle shows `fifo_count`=0, `coalesce_count`=0, and no output valid; the buffered entries are never emitted.
- Same queue, different func (queue=3 with func=1, then queue=3 with func=2):
  - Required: both entries are written and both are emitted; no coalesce.
